// File: rtl/wta_pkg.sv
// ============================================================================
// Module   : wta_pkg
// Purpose  : Shared FSM state encoding and default sizing for the WTA block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } wta_state_e;

    localparam int WTA_N_CH = 4;
    localparam int WTA_W    = 4;
    localparam int WTA_HYST = 0;

endpackage

`default_nettype wire

// File: rtl/wta_cmp.sv
// ============================================================================
// Module   : wta_cmp
// Purpose  : Combinational challenger-vs-best compare with incumbent bonus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wta_cmp #(
    parameter int W    = 4,
    parameter int HYST = 0
) (
    input  logic [W-1:0] chal_cur_i,
    input  logic [W-1:0] best_cur_i,
    input  logic         chal_inc_i,
    input  logic         best_inc_i,
    output logic         take_challenger_o
);

    localparam logic [W:0] HYST_V = (W+1)'(HYST);

    // One extra bit of headroom: max current plus max bonus still fits.
    logic [W:0] chal_eff;
    logic [W:0] best_eff;

    assign chal_eff = {1'b0, chal_cur_i} + (chal_inc_i ? HYST_V : '0);
    assign best_eff = {1'b0, best_cur_i} + (best_inc_i ? HYST_V : '0);

    assign take_challenger_o = (chal_eff >= best_eff);

endmodule

`default_nettype wire

// File: rtl/wta_seq.sv
// ============================================================================
// Module   : wta_seq
// Purpose  : Sequential winner-take-all over N_CH channels with hysteresis.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wta_seq
    import wta_pkg::*;
#(
    parameter int N_CH = WTA_N_CH,
    parameter int W    = WTA_W,
    parameter int HYST = WTA_HYST,
    parameter int IW   = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] current,
    input  logic              clr_hist,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_CH*W-1:0] u_out,
    output logic [IW-1:0]     winner_idx,
    output logic              busy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

    wta_state_e        state_q;
    logic [N_CH*W-1:0] vec_q;
    logic [IW-1:0]     best_q;
    logic [IW-1:0]     scan_q;
    logic              bonus_vld_q;
    logic              prev_vld_q;
    logic [IW-1:0]     prev_idx_q;
    logic              out_valid_q;
    logic [N_CH*W-1:0] u_out_q;
    logic [IW-1:0]     winner_q;

    logic [W-1:0]      lane [N_CH];
    logic              take;
    logic [IW-1:0]     winner_d;
    logic [N_CH*W-1:0] u_out_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        assign lane[g] = vec_q[g*W +: W];
        assign u_out_d[g*W +: W] = (winner_d == IW'(g)) ? lane[g] : '0;
    end

    // Bonus uses the history snapshot taken at acceptance, not the live flag.
    wta_cmp #(
        .W    (W),
        .HYST (HYST)
    ) u_cmp (
        .chal_cur_i        (lane[scan_q]),
        .best_cur_i        (lane[best_q]),
        .chal_inc_i        (bonus_vld_q && (scan_q == prev_idx_q)),
        .best_inc_i        (bonus_vld_q && (best_q == prev_idx_q)),
        .take_challenger_o (take)
    );

    assign winner_d = take ? scan_q : best_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            best_q      <= '0;
            scan_q      <= '0;
            bonus_vld_q <= 1'b0;
            prev_vld_q  <= 1'b0;
            prev_idx_q  <= '0;
            out_valid_q <= 1'b0;
            u_out_q     <= '0;
            winner_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (in_valid) begin
                        vec_q       <= current;
                        best_q      <= '0;
                        scan_q      <= IW'(1);
                        bonus_vld_q <= prev_vld_q;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    best_q <= winner_d;
                    if (scan_q == LAST_IDX) begin
                        winner_q    <= winner_d;
                        u_out_q     <= u_out_d;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        scan_q <= scan_q + IW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        prev_idx_q  <= winner_q;
                        prev_vld_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
            // Placed last so a clear beats a coincident handshake.
            if (clr_hist) begin
                prev_vld_q <= 1'b0;
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == SCAN) || (state_q == HOLD);
    assign out_valid  = out_valid_q;
    assign u_out      = u_out_q;
    assign winner_idx = winner_q;

endmodule

`default_nettype wire
